apb_master_mux: RTL and testbench
=================================

# apb_master_mux

Parametrised APB4 requester that turns a valid/ready command interface into APB transfers toward up to NUM_SLV completers. It decodes a one-hot PSEL from the address, drives PSTRB and PPROT, and returns read data and error status on a single-cycle response port. A programmable wait-state timeout keeps a hung completer from stalling the bus. Sits between the system-side command source and the APB completer fabric.

## Interface
- ADDR_W, 32: PADDR / req_addr width.
- DATA_W, 32: data width; must be 8, 16 or 32.
- NUM_SLV, 4: completer count, 1..16; PSEL width.
- SEL_LSB, 12: LSB of the slave-index field in the address; field width is SW = max(1, $clog2(NUM_SLV)).
- TIMEOUT, 16: maximum ACCESS cycles with PREADY low before abort; 0 disables the timeout.

- PCLK  in  1  clock; all logic on the rising edge.
- PRESETn  in  1  reset; synchronous, active-low.
- req_valid  in  1  command valid.
- req_ready  out  1  command accepted when high together with req_valid.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  write data.
- req_strb  in  DATA_W/8  write byte strobes.
- req_prot  in  3  PPROT value.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  PSLVERR, decode error or timeout.
- rsp_timeout  out  1  error cause is the timeout.
- PADDR  out  ADDR_W; PWRITE  out  1; PWDATA  out  DATA_W; PSTRB  out  DATA_W/8; PPROT  out  3.
- PSEL  out  NUM_SLV  one-hot select.
- PENABLE  out  1.
- PREADY  in  1; PRDATA  in  DATA_W; PSLVERR  in  1.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, register the address, control and data fields.
  - Compute idx = req_addr[SEL_LSB +: SW].
  - If idx < NUM_SLV, go to SETUP. Otherwise go to RESP with rsp_err = 1 (decode error); no bus activity.
- SETUP:
  - PSEL[idx] = 1, PENABLE = 0.
  - PADDR, PWRITE, PWDATA, PSTRB and PPROT are valid.
  - Next state is ACCESS.
- ACCESS:
  - PENABLE = 1. All bus outputs stay stable.
  - PREADY = 1: capture PRDATA on reads only; capture PSLVERR; go to RESP.
  - PREADY = 0: increment the wait counter. When the counter reaches TIMEOUT (TIMEOUT > 0), go to RESP with rsp_err = 1 and rsp_timeout = 1.
- RESP:
  - rsp_valid = 1 for exactly one cycle.
  - PSEL = 0, PENABLE = 0.
  - Next state is IDLE.
- PSTRB is driven to 0 on reads regardless of req_strb.
- PSLVERR is ignored unless PREADY is high in ACCESS.
- PADDR, PWRITE, PWDATA, PSTRB and PPROT hold their last values when idle. PSEL is all-zero outside SETUP and ACCESS.
- The response port has no back-pressure; the consumer must accept every rsp_valid pulse.

## Timing
- All outputs are registered, except req_ready, which is decoded from state.
- Reset (PRESETn low at a clock edge):
  - State goes to IDLE.
  - PADDR, PWDATA, PSTRB, PPROT, PWRITE, PSEL, PENABLE, rsp_* and the wait counter go to 0.
  - req_ready = 0 while PRESETn is low.
- Reset mid-transfer: abort at that edge; no response is produced.
- Zero-wait transfer, request accepted at edge E:
  - SETUP is cycle E+1, ACCESS is E+2, rsp_valid is E+3, and req_ready is high again at E+4.
  - Sustained throughput is one transfer per 4 cycles.
- Each PREADY-low cycle in ACCESS adds one cycle of latency.
- Timeout: with TIMEOUT = N, rsp_valid is asserted on the cycle after the N-th consecutive PREADY-low ACCESS cycle.
- PREADY high on the same edge the counter reaches N: the transfer completes normally; PREADY takes priority.
- Decode error: rsp_valid is asserted at E+1.
- The wait counter clears on every entry into SETUP. It is $clog2(TIMEOUT+1) bits wide and saturates.

## Structure
- The shared package apb_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS, RESP);
  - the PPROT bit constants (privileged, non-secure, instruction);
  - the response error-cause encoding.
- Sub-module apb_sel_decode (combinational, parametrised by NUM_SLV, SEL_LSB and ADDR_W) maps the address to a one-hot select and an out-of-range flag.

## Test plan
- Write: addr 0x0000_1004, data 0xDEAD_BEEF, strb 0xF, PREADY always high. Required:
  - PSEL = 0b0010 with PENABLE = 0 at E+1;
  - PENABLE = 1 at E+2;
  - rsp_valid at E+3 with rsp_err = 0.
- Read: addr 0x0000_3000; the completer inserts 2 wait states, then returns PRDATA 0x1234_5678. Required:
  - rsp_rdata = 0x1234_5678 at E+5;
  - PSTRB = 0 throughout.
- Read with PSLVERR = 1 alongside PREADY = 1. Required: rsp_err = 1, rsp_timeout = 0, rsp_rdata = 0.
- TIMEOUT = 4, PREADY held low. Required:
  - exactly 4 ACCESS cycles;
  - rsp_err = 1 and rsp_timeout = 1;
  - PSEL returns to 0 and req_ready returns to 1.
- NUM_SLV = 3, addr 0x0000_3000 (idx 3). Required: no PSEL activity; rsp_err = 1 at E+1.
- PRESETn driven low during ACCESS. Required:
  - all outputs are 0 at the next edge;
  - no rsp_valid is produced;
  - a subsequent write completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM states, PPROT bit constants and response error causes
package apb_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;
    typedef enum logic [1:0] {ERR_NONE, ERR_SLV, ERR_DECODE, ERR_TIMEOUT} err_e;
    localparam logic [2:0] PROT_PRIV  = 3'b001;
    localparam logic [2:0] PROT_NSEC  = 3'b010;
    localparam logic [2:0] PROT_INSTR = 3'b100;
endpackage

// File: rtl/apb_sel_decode.sv
// apb_sel_decode: address slave-index field to one-hot select plus out-of-range flag
module apb_sel_decode #(
    parameter int NUM_SLV = 4,
    parameter int SEL_LSB = 12,
    parameter int ADDR_W  = 32
) (
    input  logic [ADDR_W-1:0]  i_addr,
    output logic [NUM_SLV-1:0] o_sel,
    output logic               o_oor
);
    localparam int SW = NUM_SLV > 1 ? $clog2(NUM_SLV) : 1;
    logic [SW-1:0] w_idx;
    logic          w_unused;
    always_comb begin
        w_idx    = i_addr[SEL_LSB +: SW];
        o_oor    = 32'(w_idx) >= NUM_SLV;
        o_sel    = o_oor ? '0 : NUM_SLV'(1) << w_idx;
        w_unused = ^i_addr;
    end
endmodule

// File: rtl/apb_master_mux.sv
// apb_master_mux: valid/ready command to APB4 requester with one-hot completer select and wait-state timeout
module apb_master_mux
    import apb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4,
    parameter int SEL_LSB = 12,
    parameter int TIMEOUT = 16
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_strb,
    input  logic [2:0]          req_prot,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_timeout,
    output logic [ADDR_W-1:0]   PADDR,
    output logic                PWRITE,
    output logic [DATA_W-1:0]   PWDATA,
    output logic [DATA_W/8-1:0] PSTRB,
    output logic [2:0]          PPROT,
    output logic [NUM_SLV-1:0]  PSEL,
    output logic                PENABLE,
    input  logic                PREADY,
    input  logic [DATA_W-1:0]   PRDATA,
    input  logic                PSLVERR
);
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    state_e             r_state, w_state_nxt;
    err_e               r_cause;
    logic [CW-1:0]      r_wait, w_wait_nxt;
    logic [NUM_SLV-1:0] w_sel;
    logic               w_oor, w_hit;

    apb_sel_decode #(.NUM_SLV(NUM_SLV), .SEL_LSB(SEL_LSB), .ADDR_W(ADDR_W)) u_dec (
        .i_addr(req_addr),
        .o_sel (w_sel),
        .o_oor (w_oor)
    );

    assign req_ready   = PRESETn && r_state == IDLE;
    assign rsp_err     = r_cause != ERR_NONE;
    assign rsp_timeout = r_cause == ERR_TIMEOUT;

    always_comb begin
        w_wait_nxt  = &r_wait ? r_wait : r_wait + 1'b1;
        w_hit       = TIMEOUT != 0 && w_wait_nxt == CW'(TIMEOUT);
        w_state_nxt = r_state == IDLE   ? (req_valid ? (w_oor ? RESP : SETUP) : IDLE) :
                      r_state == SETUP  ? ACCESS :
                      r_state == ACCESS ? (PREADY || w_hit ? RESP : ACCESS) : IDLE;
    end

    always_ff @(posedge PCLK)
        r_state <= !PRESETn ? IDLE : w_state_nxt;

    // PREADY wins over a timeout landing on the same edge
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            PSTRB     <= '0;
            PPROT     <= '0;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            r_cause   <= ERR_NONE;
            r_wait    <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (r_state)
                IDLE: if (req_valid) begin
                    PADDR     <= req_addr;
                    PWRITE    <= req_write;
                    PWDATA    <= req_wdata;
                    PSTRB     <= req_write ? req_strb : '0;
                    PPROT     <= req_prot;
                    PSEL      <= w_sel;
                    r_wait    <= '0;
                    rsp_valid <= w_oor;
                    r_cause   <= w_oor ? ERR_DECODE : ERR_NONE;
                end
                SETUP: PENABLE <= 1'b1;
                ACCESS: begin
                    r_wait <= PREADY ? r_wait : w_wait_nxt;
                    if (PREADY || w_hit) begin
                        PSEL      <= '0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        r_cause   <= PREADY ? (PSLVERR ? ERR_SLV : ERR_NONE) : ERR_TIMEOUT;
                        rsp_rdata <= PREADY && !PWRITE && !PSLVERR ? PRDATA : '0;
                    end
                end
                RESP: begin
                    rsp_rdata <= '0;
                    r_cause   <= ERR_NONE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_apb_master_mux.sv
// tb_apb_master_mux: directed checks of the APB requester (4 completers, TIMEOUT 4) plus a 3-completer decode instance
module tb_apb_master_mux;
    import apb_pkg::*;
    logic        PCLK, PRESETn;
    logic        req_valid, req_valid3, req_write;
    logic [31:0] req_addr, req_wdata, PRDATA;
    logic [3:0]  req_strb;
    logic [2:0]  req_prot;
    logic        PREADY, PSLVERR;
    logic        req_ready, rsp_valid, rsp_err, rsp_timeout, PWRITE, PENABLE;
    logic [31:0] rsp_rdata, PADDR, PWDATA;
    logic [3:0]  PSTRB, PSEL;
    logic [2:0]  PPROT;
    logic        req_ready3, rsp_valid3, rsp_err3, rsp_timeout3, pwrite3, penable3;
    logic [31:0] rsp_rdata3, paddr3, pwdata3;
    logic [3:0]  pstrb3;
    logic [2:0]  pprot3, psel3;
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_access;

    apb_master_mux #(.NUM_SLV(4), .TIMEOUT(4)) u_dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .req_prot(req_prot), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PPROT(PPROT), .PSEL(PSEL), .PENABLE(PENABLE), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
    );

    apb_master_mux #(.NUM_SLV(3), .TIMEOUT(4)) u_dut3 (
        .PCLK(PCLK), .PRESETn(PRESETn), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .req_prot(req_prot), .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3),
        .rsp_timeout(rsp_timeout3), .PADDR(paddr3), .PWRITE(pwrite3), .PWDATA(pwdata3), .PSTRB(pstrb3),
        .PPROT(pprot3), .PSEL(psel3), .PENABLE(penable3), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    // returns one cycle after the accepting edge, i.e. in the SETUP cycle
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [2:0] p);
        check("ready_before_issue", req_ready, 1);
        req_write = w; req_addr = a; req_wdata = d; req_strb = s; req_prot = p;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
    endtask

    initial begin
        PRESETn = 1'b0; req_valid = 1'b0; req_valid3 = 1'b0; req_write = 1'b0;
        req_addr = '0; req_wdata = '0; req_strb = '0; req_prot = '0;
        PREADY = 1'b1; PRDATA = '0; PSLVERR = 1'b0;
        repeat (3) step();
        check("rst_ready", req_ready, 0);
        check("rst_psel", PSEL, 0);
        check("rst_penable", PENABLE, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_paddr", PADDR, 0);
        PRESETn = 1'b1;
        #1 check("ready_after_rst", req_ready, 1);

        // zero-wait write to completer 1
        issue(1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, PROT_PRIV);
        check("wr_setup_psel", PSEL, 4'b0010);
        check("wr_setup_penable", PENABLE, 0);
        check("wr_setup_paddr", PADDR, 32'h0000_1004);
        check("wr_setup_pwdata", PWDATA, 32'hDEAD_BEEF);
        check("wr_setup_pstrb", PSTRB, 4'hF);
        check("wr_setup_pprot", PPROT, PROT_PRIV);
        check("wr_setup_pwrite", PWRITE, 1);
        check("wr_setup_ready", req_ready, 0);
        step();
        check("wr_access_penable", PENABLE, 1);
        check("wr_access_psel", PSEL, 4'b0010);
        step();
        check("wr_rsp_valid", rsp_valid, 1);
        check("wr_rsp_err", rsp_err, 0);
        check("wr_rsp_rdata", rsp_rdata, 0);
        check("wr_rsp_psel", PSEL, 0);
        step();
        check("wr_idle_ready", req_ready, 1);
        check("wr_idle_rsp_valid", rsp_valid, 0);
        check("wr_idle_paddr_hold", PADDR, 32'h0000_1004);

        // read from completer 3 with two wait states
        PREADY = 1'b0; PRDATA = 32'h1234_5678;
        issue(0, 32'h0000_3000, 32'hAAAA_AAAA, 4'hF, 3'b000);
        check("rd_setup_psel", PSEL, 4'b1000);
        check("rd_setup_pstrb", PSTRB, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("rd_wait_penable", PENABLE, 1);
            check("rd_wait_rsp_valid", rsp_valid, 0);
            check("rd_wait_pstrb", PSTRB, 0);
            if (i == 2) PREADY = 1'b1;
        end
        step();
        check("rd_rsp_valid", rsp_valid, 1);
        check("rd_rsp_rdata", rsp_rdata, 32'h1234_5678);
        check("rd_rsp_err", rsp_err, 0);
        step();

        // slave error on a read
        PSLVERR = 1'b1; PRDATA = 32'hCAFE_F00D;
        issue(0, 32'h0000_2000, 32'h0, 4'hF, PROT_NSEC);
        step();
        step();
        check("slverr_rsp_valid", rsp_valid, 1);
        check("slverr_rsp_err", rsp_err, 1);
        check("slverr_rsp_timeout", rsp_timeout, 0);
        check("slverr_rsp_rdata", rsp_rdata, 0);
        PSLVERR = 1'b0;
        step();

        // timeout with PREADY held low
        PREADY = 1'b0;
        issue(1, 32'h0000_0000, 32'h1111_2222, 4'h3, 3'b000);
        n_access = 0;
        for (int i = 0; i < 20 && !rsp_valid; i++) begin
            step();
            if (PENABLE) n_access++;
        end
        check("to_rsp_valid", rsp_valid, 1);
        check("to_access_cycles", n_access, 4);
        check("to_rsp_err", rsp_err, 1);
        check("to_rsp_timeout", rsp_timeout, 1);
        check("to_psel", PSEL, 0);
        step();
        check("to_ready", req_ready, 1);
        check("to_rsp_valid_clear", rsp_valid, 0);

        // PREADY arrives on the edge the counter would reach TIMEOUT
        PRDATA = 32'h0BAD_C0DE;
        issue(0, 32'h0000_1000, 32'h0, 4'hF, 3'b000);
        for (int i = 0; i < 4; i++) begin
            step();
            check("edge_wait_penable", PENABLE, 1);
            if (i == 3) PREADY = 1'b1;
        end
        step();
        check("edge_rsp_valid", rsp_valid, 1);
        check("edge_rsp_err", rsp_err, 0);
        check("edge_rsp_timeout", rsp_timeout, 0);
        check("edge_rsp_rdata", rsp_rdata, 32'h0BAD_C0DE);
        step();

        // decode error on the 3-completer instance
        check("dec_ready3", req_ready3, 1);
        req_write = 1'b0; req_addr = 32'h0000_3000; req_valid3 = 1'b1;
        step();
        req_valid3 = 1'b0;
        check("dec_rsp_valid3", rsp_valid3, 1);
        check("dec_rsp_err3", rsp_err3, 1);
        check("dec_rsp_timeout3", rsp_timeout3, 0);
        check("dec_psel3", psel3, 0);
        check("dec_penable3", penable3, 0);
        step();
        check("dec_idle_psel3", psel3, 0);
        check("dec_idle_rsp_valid3", rsp_valid3, 0);
        check("dec_idle_ready3", req_ready3, 1);

        // reset asserted mid-ACCESS
        PREADY = 1'b0;
        issue(1, 32'h0000_1008, 32'h7777_8888, 4'hF, PROT_INSTR);
        step();
        check("rstmid_penable", PENABLE, 1);
        PRESETn = 1'b0;
        step();
        check("rstmid_psel", PSEL, 0);
        check("rstmid_penable0", PENABLE, 0);
        check("rstmid_paddr", PADDR, 0);
        check("rstmid_pwdata", PWDATA, 0);
        check("rstmid_pstrb", PSTRB, 0);
        check("rstmid_pprot", PPROT, 0);
        check("rstmid_pwrite", PWRITE, 0);
        check("rstmid_rsp_valid", rsp_valid, 0);
        check("rstmid_ready", req_ready, 0);
        PRESETn = 1'b1; PREADY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rstmid_no_rsp", rsp_valid, 0);
        end
        issue(1, 32'h0000_2010, 32'h55AA_55AA, 4'b0011, PROT_NSEC | PROT_INSTR);
        check("post_psel", PSEL, 4'b0100);
        check("post_pstrb", PSTRB, 4'b0011);
        check("post_pprot", PPROT, 3'b110);
        step();
        step();
        check("post_rsp_valid", rsp_valid, 1);
        check("post_rsp_err", rsp_err, 0);
        step();
        check("post_ready", req_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
